// File: rtl/beam_delay_sum_scheduler.sv
// Delay-and-sum beam scheduler: per frame, reads each channel buffer once at its steering delay and sums the samples.
// Optional build macro BEAM_MEAN_EN: output the floor mean (sum >> CH_W) instead of the raw sum.
module beam_delay_sum_scheduler #(
    parameter int NUM_CHANNELS        = 8,
    parameter int NUMBER_OF_BITS      = 8,
    parameter int SAMPLES_BUFFER_SIZE = 10,
    localparam int CH_W  = $clog2(NUM_CHANNELS),
    localparam int IDX_W = $clog2(SAMPLES_BUFFER_SIZE) + 1,
    localparam int SUM_W = NUMBER_OF_BITS + CH_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sample_tick,
    input  logic                      cfg_we,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [IDX_W-1:0]          cfg_delay,
    output logic                      cfg_ready,
    output logic                      rd_valid,
    output logic [CH_W-1:0]           rd_ch,
    output logic [IDX_W-1:0]          rd_index,
    input  logic [NUMBER_OF_BITS-1:0] rd_data,
    output logic [SUM_W-1:0]          sum_out,
    output logic                      sum_valid,
    output logic                      busy,
    output logic                      overrun
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   delay_tab [NUM_CHANNELS];
    logic               vld_p1;
    logic [SUM_W-1:0]   acc_p1;
    logic [SUM_W-1:0]   acc_next;
    logic               cfg_hit;
    logic [IDX_W-1:0]   cfg_val;
    logic [CH_W-1:0]    next_ch;

    function automatic logic [IDX_W-1:0] clamp_delay(input logic [IDX_W-1:0] d);
        if (int'(d) >= SAMPLES_BUFFER_SIZE)
            return IDX_W'(SAMPLES_BUFFER_SIZE - 1);
        return d;
    endfunction

    function automatic logic [SUM_W-1:0] beam_out(input logic [SUM_W-1:0] a);
`ifdef BEAM_MEAN_EN
        return a >> CH_W;
`else
        return a;
`endif
    endfunction

    assign busy      = (state != IDLE);
    assign cfg_ready = !busy;
    assign cfg_hit   = cfg_we && !busy && (int'(cfg_ch) < NUM_CHANNELS);
    assign cfg_val   = clamp_delay(cfg_delay);
    assign next_ch   = rd_ch + CH_W'(1);
    assign acc_next  = acc_p1 + SUM_W'(rd_data);

    // p1: accumulate the sample returned one cycle after each read request
    always_ff @(posedge clk) begin
        if (state == IDLE && sample_tick)
            acc_p1 <= '0;
        else if (vld_p1)
            acc_p1 <= acc_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rd_valid  <= 1'b0;
            rd_ch     <= '0;
            rd_index  <= '0;
            vld_p1    <= 1'b0;
            sum_valid <= 1'b0;
            sum_out   <= '0;
            overrun   <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++)
                delay_tab[i] <= '0;
        end else begin
            vld_p1    <= rd_valid;
            sum_valid <= 1'b0;
            if (cfg_hit)
                delay_tab[cfg_ch] <= cfg_val;
            if (sample_tick && busy)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state    <= ISSUE;
                        rd_valid <= 1'b1;
                        rd_ch    <= '0;
                        // a write to channel 0 in the tick cycle must already steer the first read
                        rd_index <= (cfg_hit && cfg_ch == '0) ? cfg_val : delay_tab[0];
                    end
                end
                ISSUE: begin
                    if (rd_ch == CH_W'(NUM_CHANNELS - 1)) begin
                        state    <= DRAIN;
                        rd_valid <= 1'b0;
                    end else begin
                        rd_ch    <= next_ch;
                        rd_index <= delay_tab[next_ch];
                    end
                end
                DRAIN: begin
                    state     <= DONE;
                    sum_out   <= beam_out(acc_next);
                    sum_valid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_beam_delay_sum_scheduler.sv
// Directed bench for beam_delay_sum_scheduler: vector table of delay programs and data patterns plus multi-cycle corner sequences.
module tb_beam_delay_sum_scheduler;

    logic        clk = 1'b0;
    logic        reset, sample_tick, cfg_we;
    logic [2:0]  cfg_ch;
    logic [4:0]  cfg_delay;
    logic        cfg_ready, rd_valid;
    logic [2:0]  rd_ch;
    logic [4:0]  rd_index;
    logic [7:0]  rd_data;
    logic [10:0] sum_out;
    logic        sum_valid, busy, overrun;

    int total = 0;
    int bad = 0;
    int sv_count = 0;
    int mode = 0;
    int base;
    logic [4:0] exp_dly [8];

    typedef struct {
        logic [4:0] d3_in;
        logic [4:0] d5_in;
        logic [4:0] d3_exp;
        logic [4:0] d5_exp;
        int         m;
        int         raw;
        int         mean;
    } vec_t;
    vec_t vec [4];

    beam_delay_sum_scheduler dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .cfg_ready(cfg_ready),
        .rd_valid(rd_valid), .rd_ch(rd_ch), .rd_index(rd_index), .rd_data(rd_data),
        .sum_out(sum_out), .sum_valid(sum_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (sum_valid) sv_count++;

    function automatic int pick(input int raw, input int mean);
`ifdef BEAM_MEAN_EN
        return mean;
`else
        return raw;
`endif
    endfunction

    function automatic logic [7:0] model(input int m, input logic [2:0] ch, input logic [4:0] idx);
        case (m)
            0:       return 8'(ch) + 8'd1;
            1:       return 8'd255;
            default: return 8'(ch) + 8'(idx);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // buffer model: answers one cycle after each read request
    task automatic step();
        logic       pv;
        logic [2:0] pc;
        logic [4:0] pi;
        pv = rd_valid; pc = rd_ch; pi = rd_index;
        @(posedge clk);
        #1;
        rd_data = pv ? model(mode, pc, pi) : 8'd0;
    endtask

    task automatic program_delay(input logic [2:0] ch, input logic [4:0] d);
        chk("cfg_ready_idle", cfg_ready, 1);
        cfg_we = 1'b1; cfg_ch = ch; cfg_delay = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic run_frame(input int m, input int exp_sum, input bit cfg_also,
                             input logic [2:0] c, input logic [4:0] d);
        mode = m;
        sample_tick = 1'b1;
        if (cfg_also) begin
            cfg_we = 1'b1; cfg_ch = c; cfg_delay = d;
        end
        step();
        sample_tick = 1'b0;
        cfg_we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("issue_rd_valid", rd_valid, 1);
            chk("issue_rd_ch", rd_ch, k);
            chk("issue_rd_index", rd_index, exp_dly[k]);
            step();
        end
        chk("drain_rd_valid", rd_valid, 0);
        chk("drain_sum_valid", sum_valid, 0);
        step();
        chk("done_sum_valid", sum_valid, 1);
        chk("done_sum_out", sum_out, exp_sum);
        step();
        chk("idle_sum_valid", sum_valid, 0);
        chk("idle_busy", busy, 0);
        chk("hold_sum_out", sum_out, exp_sum);
    endtask

    initial begin
        vec[0] = '{d3_in: 5'd0,  d5_in: 5'd0,  d3_exp: 5'd0, d5_exp: 5'd0, m: 0, raw: 36,   mean: 4};
        vec[1] = '{d3_in: 5'd9,  d5_in: 5'd12, d3_exp: 5'd9, d5_exp: 5'd9, m: 0, raw: 36,   mean: 4};
        vec[2] = '{d3_in: 5'd31, d5_in: 5'd4,  d3_exp: 5'd9, d5_exp: 5'd4, m: 1, raw: 2040, mean: 255};
        vec[3] = '{d3_in: 5'd1,  d5_in: 5'd9,  d3_exp: 5'd1, d5_exp: 5'd9, m: 2, raw: 38,   mean: 4};
        for (int i = 0; i < 8; i++) exp_dly[i] = 5'd0;

        reset = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_delay = '0; rd_data = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_ch", rd_ch, 0);
        chk("rst_rd_index", rd_index, 0);
        chk("rst_sum_out", sum_out, 0);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_overrun", overrun, 0);

        for (int i = 0; i < 4; i++) begin
            program_delay(3'd3, vec[i].d3_in);
            program_delay(3'd5, vec[i].d5_in);
            exp_dly[3] = vec[i].d3_exp;
            exp_dly[5] = vec[i].d5_exp;
            run_frame(vec[i].m, pick(vec[i].raw, vec[i].mean), 1'b0, 3'd0, 5'd0);
        end

        // write to channel 0 in the same cycle as the tick
        exp_dly[0] = 5'd6;
        run_frame(2, pick(44, 5), 1'b1, 3'd0, 5'd6);

        // second tick and a config write while scanning
        mode = 0;
        sample_tick = 1'b1; step(); sample_tick = 1'b0;
        step(); step();
        cfg_we = 1'b1; cfg_ch = 3'd2; cfg_delay = 5'd7;
        chk("busy_cfg_ready", cfg_ready, 0);
        chk("busy_flag", busy, 1);
        step();
        cfg_we = 1'b0; sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        chk("overrun_set", overrun, 1);
        base = sv_count;
        for (int i = 0; i < 10; i++) step();
        chk("overrun_one_sum_valid", sv_count - base, 1);
        chk("overrun_frame_sum", sum_out, pick(36, 4));
        chk("overrun_sticky", overrun, 1);
        run_frame(0, pick(36, 4), 1'b0, 3'd0, 5'd0);
        chk("overrun_still", overrun, 1);

        // reset in the middle of a scan
        mode = 0;
        sample_tick = 1'b1; step(); sample_tick = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_valid", rd_valid, 0);
        chk("midrst_rd_ch", rd_ch, 0);
        chk("midrst_rd_index", rd_index, 0);
        chk("midrst_sum_out", sum_out, 0);
        chk("midrst_overrun", overrun, 0);
        base = sv_count;
        for (int i = 0; i < 8; i++) step();
        chk("midrst_no_sum_valid", sv_count - base, 0);
        for (int i = 0; i < 8; i++) exp_dly[i] = 5'd0;
        run_frame(2, pick(28, 3), 1'b0, 3'd0, 5'd0);

        // back-to-back frames at the minimum period
        base = sv_count;
        for (int f = 0; f < 20; f++) run_frame(0, pick(36, 4), 1'b0, 3'd0, 5'd0);
        chk("stream_sum_valid_count", sv_count - base, 20);
        chk("stream_overrun", overrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
